sa_job_sequencer: RTL and testbench
===================================

// Module: sa_job_sequencer
// PURPOSE
//  Sequences one 8x8 systolic-array job: clears the array, fetches N packed operand rows from a
//  row-addressed buffer, writes each into the array register file (SA_WRITE/SA_IDX/SA_DIN), then
//  runs the compute phase (SA_EN=1, SA_WRITE=0) for a fixed cycle count and signals DONE.
//  Sits between the host/job queue and the SystolicArray top; the array outputs Y_* are read by the host after DONE.
// PARAMETERS
//  N        8            array dimension; rows loaded per job, SA_IDX range 0..N-1
//  DW       16           element width; SA_DIN/RD_DATA carry 2*N elements of DW bits
//  AW       8            operand buffer row-address width
//  CMP_CYC  3*N-2 (22)   compute-phase cycles after last row write
// PORTS
//  CLK        in   1          clock, all state on rising edge
//  RST        in   1          asynchronous, active-low reset
//  START      in   1          job request; accepted only in IDLE
//  BASE       in   AW         first operand row address; sampled when START accepted
//  ABORT      in   1          cancels a running job (any state but IDLE)
//  BUSY       out  1          high from START acceptance until return to IDLE
//  DONE       out  1          one-cycle pulse on normal completion
//  RD_REQ     out  1          operand row read request (one outstanding max)
//  RD_ADDR    out  AW         row address = BASE + row
//  RD_VALID   in   1          RD_DATA valid this cycle; 1..any cycles after RD_REQ
//  RD_DATA    in   2*N*DW     packed row, element k at [k*DW +: DW]
//  SA_CLR     out  1          active-high clear of array accumulators
//  SA_EN      out  1          array enable
//  SA_WRITE   out  1          array register-file write strobe
//  SA_IDX     out  $clog2(N)  register-file row index
//  SA_DIN     out  2*N*DW     row data to array (DIN_0..DIN_15 packed)
// BEHAVIOUR
//  All outputs registered; reset value 0 for every output; state=IDLE, counters 0.
//  FSM: IDLE -> CLEAR -> REQ -> WAIT -> WRITE -> (REQ | COMPUTE) -> FIN -> IDLE.
//  IDLE: START=1 -> latch BASE, row=0, BUSY=1, go CLEAR. START ignored in all other states.
//  CLEAR: SA_CLR=1 for exactly one cycle -> REQ.
//  REQ: RD_REQ=1, RD_ADDR=BASE+row (mod 2^AW, wrap allowed) for one cycle -> WAIT.
//  WAIT: hold until RD_VALID=1; capture RD_DATA into SA_DIN; -> WRITE. RD_VALID outside WAIT is ignored.
//  WRITE: SA_EN=1, SA_WRITE=1, SA_IDX=row for exactly one cycle; SA_DIN stable.
//    row<N-1 -> row+1, REQ; row==N-1 -> cnt=0, COMPUTE.
//  SA_EN=0 in CLEAR/REQ/WAIT so the array does not advance while operands are pending.
//  COMPUTE: SA_EN=1, SA_WRITE=0; cnt increments; after CMP_CYC cycles (cnt==CMP_CYC-1) -> FIN.
//  FIN: DONE=1 one cycle, BUSY=0 next cycle -> IDLE. Y_* valid from FIN until next CLEAR.
//  Minimum job latency (RD_VALID one cycle after RD_REQ): 1 + 3*N + CMP_CYC + 1 cycles START->DONE.
//  ABORT: from any non-IDLE state next state is IDLE; SA_EN/SA_WRITE/RD_REQ drop next cycle;
//    no DONE; ABORT priority over all transitions incl. FIN; a pending read response is dropped.
//  START and ABORT in same cycle while IDLE: job not accepted.
//  RST low mid-job: immediate return to IDLE, all outputs 0; array contents undefined until next CLEAR.
// TESTING
//  Reset: RST=0 with START=1 -> all outputs 0, BUSY stays 0 until RST=1 and START sampled.
//  Single job, BASE=0x10, RD_VALID 1 cycle after each RD_REQ -> RD_ADDR 0x10..0x17 in order,
//    SA_IDX 0..7 with matching SA_DIN, 22 COMPUTE cycles, DONE at cycle 48 after START, Y_* = ref matmul.
//  Random RD_VALID latency 1..5 -> SA_EN=0 during every wait, SA_WRITE pulses exactly 8, results unchanged.
//  BASE=0xFE -> RD_ADDR 0xFE,0xFF,0x00..0x05 (wrap).
//  ABORT during WAIT on row 3 -> IDLE next cycle, no DONE, no further SA_WRITE; new START runs clean job.
//  START held high through a job -> second job begins only after return to IDLE; DONE pulses once per job.

Source files
------------

// File: rtl/sa_job_sequencer.sv
// ============================================================================
// sa_job_sequencer
// ----------------------------------------------------------------------------
// Runs one job on an NxN systolic array:
//   1. pulses the array accumulator clear,
//   2. fetches N packed operand rows from a row-addressed buffer, one read
//      outstanding at a time, starting at the base address latched at START,
//   3. writes each fetched row into the array register file,
//   4. enables the array for CMP_CYC compute cycles,
//   5. pulses DONE and returns to idle.
// The host reads the array results once DONE has pulsed.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      job request; only accepted while idle
//   base_i       first operand row address, sampled when start is accepted
//   abort_i      cancels a running job; takes priority over every transition
//   busy_o       high from start acceptance until the return to idle
//   done_o       one-cycle pulse on normal completion
//   rd_req_o     operand row read request (single cycle)
//   rd_addr_o    operand row address = base + row (wraps modulo 2^AW)
//   rd_valid_i   read response valid; only looked at while waiting for data
//   rd_data_i    packed operand row, element k at [k*DW +: DW]
//   sa_clr_o     array accumulator clear
//   sa_en_o      array enable
//   sa_write_o   array register-file write strobe
//   sa_idx_o     array register-file row index
//   sa_din_o     row data presented to the array register file
//
// Every output is a flop. The output flops are loaded from a decode of the
// next state, so each output lines up exactly with the state it belongs to.
// ============================================================================
module sa_job_sequencer #(
    parameter int N       = 8,
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int CMP_CYC = 3 * N - 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [AW-1:0]           base_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_req_o,
    output logic [AW-1:0]           rd_addr_o,
    input  logic                    rd_valid_i,
    input  logic [2*N*DW-1:0]       rd_data_i,
    output logic                    sa_clr_o,
    output logic                    sa_en_o,
    output logic                    sa_write_o,
    output logic [$clog2(N)-1:0]    sa_idx_o,
    output logic [2*N*DW-1:0]       sa_din_o
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(CMP_CYC + 1);
    localparam int RW = 2 * N * DW;

    localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CMP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        WAIT,
        WRITE,
        COMPUTE,
        FIN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [IW-1:0]   row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_req_q, rd_req_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            sa_clr_q, sa_clr_d;
    logic            sa_en_q, sa_en_d;
    logic            sa_write_q, sa_write_d;
    logic [IW-1:0]   sa_idx_q, sa_idx_d;
    logic [RW-1:0]   sa_din_q, sa_din_d;

    // ------------------------------------------------------------------------
    // Next-state logic. An abort from any busy state overrides everything,
    // including FIN, so an aborted job never produces DONE and a read
    // response arriving in the same cycle is not captured.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        sa_din_d = sa_din_q;

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A start coinciding with an abort is refused.
                    if (start_i && !abort_i) begin
                        base_d  = base_i;
                        row_d   = '0;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    state_d = REQ;
                end
                REQ: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (rd_valid_i) begin
                        sa_din_d = rd_data_i;
                        state_d  = WRITE;
                    end
                end
                WRITE: begin
                    if (row_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = REQ;
                    end
                end
                COMPUTE: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state. The array is only enabled while a
    // row is being written or during compute, so it never advances while an
    // operand read is pending. Address, index and row data hold their last
    // value outside the cycles in which they are meaningful.
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        sa_clr_d   = (state_d == CLEAR);
        rd_req_d   = (state_d == REQ);
        sa_write_d = (state_d == WRITE);
        sa_en_d    = (state_d == WRITE) || (state_d == COMPUTE);
        rd_addr_d  = rd_addr_q;
        sa_idx_d   = sa_idx_q;

        if (state_d == REQ) begin
            rd_addr_d = base_d + AW'(row_d);
        end
        if (state_d == WRITE) begin
            sa_idx_d = row_d;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            sa_clr_q   <= 1'b0;
            sa_en_q    <= 1'b0;
            sa_write_q <= 1'b0;
            sa_idx_q   <= '0;
            sa_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            sa_clr_q   <= sa_clr_d;
            sa_en_q    <= sa_en_d;
            sa_write_q <= sa_write_d;
            sa_idx_q   <= sa_idx_d;
            sa_din_q   <= sa_din_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_req_o   = rd_req_q;
    assign rd_addr_o  = rd_addr_q;
    assign sa_clr_o   = sa_clr_q;
    assign sa_en_o    = sa_en_q;
    assign sa_write_o = sa_write_q;
    assign sa_idx_o   = sa_idx_q;
    assign sa_din_o   = sa_din_q;

endmodule

// File: tb/tb_sa_job_sequencer.sv
// ============================================================================
// tb_sa_job_sequencer
// ----------------------------------------------------------------------------
// Drives sa_job_sequencer with directed job scenarios while a behavioural
// operand buffer answers read requests with random latency. Expected results
// come from the job rules themselves: N requests at base+row, N writes of the
// matching buffer rows, and a START->DONE latency of
// 1 + sum(row fetch + write) + compute cycles + 1.
// ============================================================================
module tb_sa_job_sequencer;

    localparam int N       = 8;
    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int CMP_CYC = 3 * N - 2;
    localparam int IW      = $clog2(N);
    localparam int RW      = 2 * N * DW;

    logic            clk;
    logic            rstN;
    logic            start;
    logic [AW-1:0]   base;
    logic            abort;
    logic            busy;
    logic            done;
    logic            rdReq;
    logic [AW-1:0]   rdAddr;
    logic            rdValid;
    logic [RW-1:0]   rdData;
    logic            saClr;
    logic            saEn;
    logic            saWrite;
    logic [IW-1:0]   saIdx;
    logic [RW-1:0]   saDin;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Operand buffer contents and responder configuration.
    logic [RW-1:0] mem [256];
    int            maxLat    = 1;
    bit            fixedLat  = 1'b1;
    int            pendCnt   = 0;
    logic [AW-1:0] pendAddr;

    // Observations collected by the monitor for the current job.
    logic [AW-1:0] addrQ [$];
    logic [IW-1:0] idxQ [$];
    logic [RW-1:0] dinQ [$];
    int            doneCycQ [$];
    int            latQ [$];
    int            enViol = 0;
    bit            outstanding = 1'b0;
    int            startCyc = 0;

    sa_job_sequencer #(
        .N(N), .DW(DW), .AW(AW), .CMP_CYC(CMP_CYC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .start_i    (start),
        .base_i     (base),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .rd_req_o   (rdReq),
        .rd_addr_o  (rdAddr),
        .rd_valid_i (rdValid),
        .rd_data_i  (rdData),
        .sa_clr_o   (saClr),
        .sa_en_o    (saEn),
        .sa_write_o (saWrite),
        .sa_idx_o   (saIdx),
        .sa_din_o   (saDin)
    );

    // Free-running clock plus a cycle counter bumped on every rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Operand buffer model: a request seen in cycle c is answered with a
    // one-cycle valid pulse in cycle c+L. When nothing is pending it throws
    // in stray valid pulses with junk data, which the sequencer must ignore.
    initial begin
        rdValid = 1'b0;
        rdData  = '0;
        forever begin
            @(negedge clk);
            rdValid = 1'b0;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    rdValid = 1'b1;
                    rdData  = mem[pendAddr];
                end
            end else if (rdReq) begin
                pendAddr = rdAddr;
                pendCnt  = fixedLat ? maxLat : $urandom_range(1, maxLat);
                latQ.push_back(pendCnt);
            end else if ($urandom_range(0, 3) == 0) begin
                rdValid = 1'b1;
                rdData  = ~mem[$urandom_range(0, 255)];
            end
        end
    end

    // Monitor: records requests, writes and DONE pulses, and counts cycles in
    // which the array is enabled while an operand fetch is still pending or
    // the clear is active, or a write strobe appears without enable.
    initial begin
        forever begin
            @(negedge clk);
            if (rdReq) begin
                addrQ.push_back(rdAddr);
                outstanding = 1'b1;
                if (saEn) enViol++;
            end else if (outstanding && !saWrite && saEn) begin
                enViol++;
            end
            if (saClr && saEn) enViol++;
            if (saWrite) begin
                idxQ.push_back(saIdx);
                dinQ.push_back(saDin);
                outstanding = 1'b0;
                if (!saEn) enViol++;
            end
            if (done) doneCycQ.push_back(cyc);
            if (!busy) outstanding = 1'b0;
        end
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [RW-1:0] observed,
                               input logic [RW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Clears the per-job observation record, configures the responder and
    // issues a single-cycle START. Clearing happens on a rising edge so it
    // never races the monitor, which only acts on falling edges.
    task automatic launchJob(input logic [AW-1:0] b, input int lat, input bit fixed);
        @(posedge clk);
        addrQ.delete();
        idxQ.delete();
        dinQ.delete();
        doneCycQ.delete();
        latQ.delete();
        enViol   = 0;
        maxLat   = lat;
        fixedLat = fixed;
        @(negedge clk);
        start = 1'b1;
        base  = b;
        @(negedge clk);
        start    = 1'b0;
        startCyc = cyc;
    endtask

    // Waits (bounded) until the requested number of DONE pulses was seen.
    task automatic waitDone(input int count, input int bound);
        int n = 0;
        while (doneCycQ.size() < count && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", doneCycQ.size(), count);
    endtask

    // Runs one complete job and waits for its completion.
    task automatic applyStimulus(input logic [AW-1:0] b, input int lat, input bit fixed);
        launchJob(b, lat, fixed);
        waitDone(1, 600);
        @(negedge clk);
        checkOutput("busyAfterDone", busy, 0);
    endtask

    // Compares the finished job with what the job rules require.
    task automatic checkJob(input logic [AW-1:0] b);
        int expLat;
        repeat (4) @(negedge clk);
        checkOutput("reqCount", addrQ.size(), N);
        checkOutput("writeCount", idxQ.size(), N);
        checkOutput("doneOnce", doneCycQ.size(), 1);
        checkOutput("enDuringWait", enViol, 0);
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            checkOutput($sformatf("rdAddr[%0d]", i), (i < addrQ.size()) ? addrQ[i] : 'x, a);
            checkOutput($sformatf("saIdx[%0d]", i), (i < idxQ.size()) ? idxQ[i] : 'x, i);
            checkOutput($sformatf("saDin[%0d]", i), (i < dinQ.size()) ? dinQ[i] : 'x, mem[a]);
        end
        expLat = 1 + CMP_CYC + 1;
        foreach (latQ[i]) expLat += latQ[i] + 2;
        if (doneCycQ.size() > 0) begin
            checkOutput("latency", doneCycQ[0] - startCyc + 1, expLat);
        end
    endtask

    // Main directed sequence.
    initial begin
        int obsLat;
        logic [AW-1:0] b;

        for (int a = 0; a < 256; a++) begin
            for (int w = 0; w < RW / 32; w++) begin
                mem[a][w*32 +: 32] = $urandom;
            end
        end

        // Reset held with START high: nothing may move.
        rstN  = 1'b0;
        start = 1'b1;
        base  = 8'h10;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetCtrl", {busy, done, rdReq, rdAddr, saClr, saEn, saWrite, saIdx}, 0);
        checkOutput("resetDin", saDin, 0);
        rstN = 1'b1;
        #1;
        checkOutput("busyBeforeSample", busy, 0);
        @(negedge clk);
        checkOutput("busyAfterSample", busy, 1);
        checkOutput("clearPulse", saClr, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortFromReq", {busy, rdReq, saEn}, 0);
        repeat (8) @(negedge clk);

        // Single job at 0x10 with one-cycle read latency: DONE 48 cycles after START.
        $display("[TB] single job, base 0x10");
        applyStimulus(8'h10, 1, 1'b1);
        obsLat = (doneCycQ.size() > 0) ? doneCycQ[0] - startCyc + 1 : -1;
        checkOutput("latency48", obsLat, 48);
        checkJob(8'h10);

        // Random read latency 1..5 on random bases.
        $display("[TB] random latency jobs");
        for (int j = 0; j < 3; j++) begin
            b = AW'($urandom_range(0, 255));
            applyStimulus(b, 5, 1'b0);
            checkJob(b);
        end

        // Address wrap past the top of the buffer.
        $display("[TB] wrap job, base 0xFE");
        applyStimulus(8'hFE, 1, 1'b1);
        checkJob(8'hFE);

        // Abort while waiting for row 3.
        $display("[TB] abort during row 3 fetch");
        launchJob(8'h40, 5, 1'b1);
        for (int n = 0; n < 200 && addrQ.size() < 4; n++) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortIdle", {busy, saEn, saWrite, rdReq}, 0);
        repeat (12) @(negedge clk);
        checkOutput("abortWrites", idxQ.size(), 3);
        checkOutput("abortNoDone", doneCycQ.size(), 0);
        checkOutput("abortReqs", addrQ.size(), 4);
        applyStimulus(8'h41, 3, 1'b0);
        checkJob(8'h41);

        // START held high: back-to-back jobs separated by one idle cycle.
        $display("[TB] start held high");
        launchJob(8'h20, 1, 1'b1);
        start = 1'b1;
        waitDone(2, 300);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("heldDoneCount", doneCycQ.size(), 2);
        checkOutput("heldWrites", idxQ.size(), 2 * N);
        if (doneCycQ.size() >= 2) begin
            checkOutput("heldGap", doneCycQ[1] - doneCycQ[0], 49);
        end

        // Reset asserted in the middle of a job clears every output at once.
        $display("[TB] reset mid-job");
        launchJob(8'h80, 2, 1'b1);
        repeat (20) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midResetCtrl", {busy, done, rdReq, rdAddr, saClr, saEn, saWrite, saIdx}, 0);
        checkOutput("midResetDin", saDin, 0);
        repeat (10) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        b = AW'($urandom_range(0, 255));
        applyStimulus(b, 4, 1'b0);
        checkJob(b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
